// File: rtl/sprite_ram_loader.sv
// Byte-stream to RAM word loader: packs bytes MSB-first into DATA_WIDTH-bit words
// and issues one registered write per word to the sprite/background RAM.
module sprite_ram_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0]      BYTE_LAST = BCW'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
    logic [BCW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  in_ready_q, we_q, busy_q, done_q;
    logic [ADDR_WIDTH:0]   len_sat;
    logic                  accept;

    assign len_sat = (length > DEPTH) ? DEPTH : length;
    assign accept  = in_valid && in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            wcnt_q     <= '0;
            bcnt_q     <= '0;
            word_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wcnt_q     <= wcnt_d;
            bcnt_q     <= bcnt_d;
            word_q     <= word_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= (state_d == COLLECT);
            we_q       <= (state_d == WRITE);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == FINISH);
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len_sat;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                    state_d = (len_sat == '0) ? FINISH : COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    word_d = (word_q << 8) | DATA_WIDTH'(in_data);
                    if (bcnt_q == BYTE_LAST) begin
                        // Write address/data are captured here so they are registered for the WRITE cycle.
                        state_d = WRITE;
                        bcnt_d  = '0;
                        waddr_d = wcnt_q[ADDR_WIDTH-1:0];
                        wdata_d = word_d;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                wcnt_d  = wcnt_q + 1'b1;
                bcnt_d  = '0;
                state_d = (wcnt_d == len_q) ? FINISH : COLLECT;
            end
            FINISH: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    assign in_ready = in_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Self-checking bench for sprite_ram_loader: random byte streams compared against
// an expected write list computed from the loader's addressing and packing rules.
module tb_sprite_ram_loader;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [AW:0]   length = '0;
    logic [7:0]    in_data = '0;
    logic          in_ready, we, busy, done;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit busy_prev = 1'b0;

    int         wr_addr[$], wr_data[$], wr_cyc[$];
    int         acc_cyc[$], done_cyc[$], fall_cyc[$];
    logic [7:0] acc_byte[$];
    logic [7:0] src[$];

    sprite_ram_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .length   (length),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Observe on the falling edge; inputs only change just after the rising edge.
    always @(negedge clk) begin
        cyc++;
        if (we) begin
            wr_addr.push_back(int'(waddr));
            wr_data.push_back(int'(wdata));
            wr_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) begin
            acc_byte.push_back(in_data);
            acc_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (busy_prev && !busy) fall_cyc.push_back(cyc);
        busy_prev = busy;
    end

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        acc_byte.delete(); acc_cyc.delete(); done_cyc.delete(); fall_cyc.delete();
    endtask

    task automatic fill_src(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back(8'($urandom));
    endtask

    task automatic pulse_start(input int len);
        length = (AW+1)'(len);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic drive_stream(input int first, input int n, input bit gaps);
        int idx = first;
        int budget = 0;
        bit acc;
        while (idx < first + n && budget < 2000) begin
            in_data  = src[idx];
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != first + n) begin
            errors++;
            $display("FAIL stream_timeout: accepted %0d bytes, required %0d", idx - first, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad = 0;
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, we, waddr, wdata, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {in_ready, we, waddr, wdata, busy, done});
        end
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (10) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_no_start: %0d cycles with activity, required 0", bad);
        end
    endtask

    task automatic test_load(input int len, input bit gaps, input string name);
        int eff = (len > DEPTH) ? DEPTH : len;
        int bad;
        clear_logs();
        fill_src(2 * eff);
        pulse_start(len);
        drive_stream(0, 2 * eff, gaps);
        wait_idle(name);
        checks++;
        if (wr_addr.size() != eff) begin
            errors++;
            $display("FAIL %s_write_count: got %0d required %0d", name, wr_addr.size(), eff);
        end
        for (int i = 0; i < eff && i < wr_addr.size(); i++) begin
            int exp_data = int'(src[2*i]) * 256 + int'(src[2*i+1]);
            checks++;
            if (wr_addr[i] != i || wr_data[i] != exp_data) begin
                errors++;
                $display("FAIL %s_write%0d: got (%0d,%h) required (%0d,%h)",
                         name, i, wr_addr[i], wr_data[i], i, exp_data);
            end
            if (2*i+1 < acc_cyc.size()) begin
                checks++;
                if (wr_cyc[i] != acc_cyc[2*i+1] + 1) begin
                    errors++;
                    $display("FAIL %s_latency%0d: we at cycle %0d required %0d",
                             name, i, wr_cyc[i], acc_cyc[2*i+1] + 1);
                end
            end
        end
        bad = (acc_byte.size() != 2 * eff) ? 1 : 0;
        for (int i = 0; i < acc_byte.size() && i < 2 * eff; i++)
            if (acc_byte[i] !== src[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_byte_stream: %0d accepted %0d bad, required %0d with 0 bad",
                     name, acc_byte.size(), bad, 2 * eff);
        end
        checks++;
        if (done_cyc.size() != 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d required 1", name, done_cyc.size());
        end else if (wr_cyc.size() > 0) begin
            checks++;
            if (done_cyc[0] != wr_cyc[wr_cyc.size()-1] + 1) begin
                errors++;
                $display("FAIL %s_done_timing: done at %0d required %0d",
                         name, done_cyc[0], wr_cyc[wr_cyc.size()-1] + 1);
            end
            checks++;
            if (fall_cyc.size() != 1 || fall_cyc[0] != done_cyc[0] + 1) begin
                errors++;
                $display("FAIL %s_busy_fall: %0d falls, first at %0d, required 1 at %0d", name,
                         fall_cyc.size(), (fall_cyc.size() > 0) ? fall_cyc[0] : -1, done_cyc[0] + 1);
            end
        end
    endtask

    task automatic test_zero_length();
        clear_logs();
        pulse_start(0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || we !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: done=%b we=%b required done=1 we=0", done, we);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_addr.size() != 0 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL zero_len_summary: writes=%0d dones=%0d required 0 and 1",
                     wr_addr.size(), done_cyc.size());
        end
    endtask

    task automatic test_abort();
        clear_logs();
        fill_src(5);
        pulse_start(4);
        drive_stream(0, 5, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_deassert: in_ready=%b busy=%b required 0 0", in_ready, busy);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (wr_addr.size() != 2 || done_cyc.size() != 0) begin
            errors++;
            $display("FAIL abort_summary: writes=%0d dones=%0d required 2 and 0",
                     wr_addr.size(), done_cyc.size());
        end
        for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
            int exp_data = int'(src[2*i]) * 256 + int'(src[2*i+1]);
            checks++;
            if (wr_addr[i] != i || wr_data[i] != exp_data) begin
                errors++;
                $display("FAIL abort_write%0d: got (%0d,%h) required (%0d,%h)",
                         i, wr_addr[i], wr_data[i], i, exp_data);
            end
        end
        // A fresh single-word load after the abort must start over at address 0.
        clear_logs();
        fill_src(2);
        pulse_start(1);
        drive_stream(0, 2, 1'b0);
        wait_idle("after_abort");
        checks++;
        if (wr_addr.size() != 1 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL after_abort_summary: writes=%0d dones=%0d required 1 and 1",
                     wr_addr.size(), done_cyc.size());
        end else begin
            checks++;
            if (wr_addr[0] != 0 || wr_data[0] != int'(src[0]) * 256 + int'(src[1])) begin
                errors++;
                $display("FAIL after_abort_write: got (%0d,%h) required (0,%h)",
                         wr_addr[0], wr_data[0], int'(src[0]) * 256 + int'(src[1]));
            end
        end
    endtask

    task automatic test_start_ignored();
        clear_logs();
        fill_src(6);
        pulse_start(3);
        drive_stream(0, 3, 1'b0);
        pulse_start(1);
        drive_stream(3, 3, 1'b0);
        wait_idle("start_ignored");
        checks++;
        if (wr_addr.size() != 3 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL start_ignored_summary: writes=%0d dones=%0d required 3 and 1",
                     wr_addr.size(), done_cyc.size());
        end
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            int exp_data = int'(src[2*i]) * 256 + int'(src[2*i+1]);
            checks++;
            if (wr_addr[i] != i || wr_data[i] != exp_data) begin
                errors++;
                $display("FAIL start_ignored_write%0d: got (%0d,%h) required (%0d,%h)",
                         i, wr_addr[i], wr_data[i], i, exp_data);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_logs();
        fill_src(8);
        pulse_start(4);
        drive_stream(0, 3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, we, waddr, wdata, busy, done} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h required 0",
                     {in_ready, we, waddr, wdata, busy, done});
        end
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (done_cyc.size() != 0 || wr_addr.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_after: dones=%0d writes=%0d busy=%b required 0 0 0",
                     done_cyc.size(), wr_addr.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_load(3, 1'b0, "basic");
        test_load(3, 1'b1, "backpressure");
        test_load(5, 1'b1, "gaps5");
        test_load(16, 1'b0, "full_depth");
        test_load(20, 1'b1, "oversize");
        test_zero_length();
        test_abort();
        test_start_ignored();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
